// File: rtl/rr_mem_arbiter_pkg.sv
// Shared sizing limits and helpers for the round-robin BRAM read arbiter and its strip_driver users.
package rr_mem_arbiter_pkg;

   localparam int MIN_CHANNELS     = 2;
   localparam int MAX_CHANNELS     = 32;
   localparam int MAX_READ_LATENCY = 4;

   // Channel index width; never below one bit so a 2-channel build still has a real index.
   function automatic int ch_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int CH_IDX_MAX_W = ch_idx_w(MAX_CHANNELS);

   // Grant tag carried alongside the BRAM read so returning data can be steered to its channel.
   typedef struct packed {
      logic                    vld;
      logic [CH_IDX_MAX_W-1:0] idx;
   } grant_tag_t;

endpackage

// File: rtl/rr_mem_arbiter_if.sv
// Requester/BRAM bundle of the arbiter: slave = arbiter side, master = strip drivers plus BRAM side.
interface rr_mem_arbiter_if #(
   parameter int NUM_CHANNELS  = 8,
   parameter int ADDRESS_WIDTH = 9,
   parameter int DATA_WIDTH    = 8
);

   logic [NUM_CHANNELS-1:0]               req;
   logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] addr;
   logic [NUM_CHANNELS-1:0]               rdy;
   logic [DATA_WIDTH-1:0]                 data;
   logic                                  mem_ren;
   logic [ADDRESS_WIDTH-1:0]              mem_raddr;
   logic [DATA_WIDTH-1:0]                 mem_rdata;

   modport slave (
      input  req, addr, mem_rdata,
      output rdy, data, mem_ren, mem_raddr
   );

   modport master (
      output req, addr, mem_rdata,
      input  rdy, data, mem_ren, mem_raddr
   );

endinterface

// File: rtl/rr_mem_arbiter_rr_picker.sv
// Combinational rotating priority encoder: first eligible channel at or after ptr, wrapping.
module rr_picker
   import rr_mem_arbiter_pkg::*;
#(
   parameter  int NUM_CHANNELS = 8,
   localparam int IDX_W        = ch_idx_w(NUM_CHANNELS)
) (
   input  logic [NUM_CHANNELS-1:0] eligible,
   input  logic [IDX_W-1:0]        ptr,
   output logic                    grant_valid,
   output logic [IDX_W-1:0]        grant_idx
);

   int j;

   // Scan from the farthest offset down so the nearest eligible channel is the last one written.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      j           = 0;
      for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= NUM_CHANNELS) j = j - NUM_CHANNELS;
         if (eligible[j]) begin
            grant_valid = 1'b1;
            grant_idx   = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/rr_mem_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among NUM_CHANNELS strip drivers, one read per clock.
// Optional MEM_ARB_STATS_EN adds saturating grant_cnt and stall_cnt outputs.
module rr_mem_arbiter
   import rr_mem_arbiter_pkg::*;
#(
   parameter int NUM_CHANNELS  = 8,
   parameter int ADDRESS_WIDTH = 9,
   parameter int DATA_WIDTH    = 8,
   parameter int READ_LATENCY  = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   rr_mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0]    grant_cnt,
   output logic [31:0]    stall_cnt
`endif
);

   localparam int IDX_W = ch_idx_w(NUM_CHANNELS);

   logic [IDX_W-1:0]         ptr;
   logic [NUM_CHANNELS-1:0]  inflight;
   logic [NUM_CHANNELS-1:0]  eligible;
   logic [NUM_CHANNELS-1:0]  grant_mask;
   logic [NUM_CHANNELS-1:0]  done_mask;
   logic                     grant_valid;
   logic [IDX_W-1:0]         grant_idx;
   logic [ADDRESS_WIDTH-1:0] raddr_q;
   logic [NUM_CHANNELS-1:0]  rdy_q;
   logic [DATA_WIDTH-1:0]    data_q;
   grant_tag_t               tag_p [READ_LATENCY+1];

   assign eligible = bus.req & ~inflight;

   rr_picker #(.NUM_CHANNELS(NUM_CHANNELS)) u_picker (
      .eligible    (eligible),
      .ptr         (ptr),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   always_comb begin
      grant_mask = '0;
      done_mask  = '0;
      if (grant_valid) grant_mask[grant_idx] = 1'b1;
      for (int c = 0; c < NUM_CHANNELS; c++)
         done_mask[c] = tag_p[READ_LATENCY].vld &&
                        (tag_p[READ_LATENCY].idx == CH_IDX_MAX_W'(c));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= '0;
         inflight <= '0;
         raddr_q  <= '0;
         rdy_q    <= '0;
         data_q   <= '0;
         for (int s = 0; s <= READ_LATENCY; s++) tag_p[s] <= '0;
      end else begin
         // Stage 0: grant, address to BRAM, tag enters the pipe
         tag_p[0] <= '{vld: grant_valid, idx: CH_IDX_MAX_W'(grant_idx)};
         if (grant_valid) begin
            raddr_q <= bus.addr[int'(grant_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            ptr     <= (grant_idx == IDX_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
         end
         // Stages 1..READ_LATENCY: tag tracks the BRAM read latency
         for (int s = 1; s <= READ_LATENCY; s++) tag_p[s] <= tag_p[s-1];
         // Output stage: steer returning word, release the channel on the same edge
         inflight <= (inflight & ~done_mask) | grant_mask;
         rdy_q    <= done_mask;
         if (|done_mask) data_q <= bus.mem_rdata;
      end
   end

   assign bus.mem_ren   = tag_p[0].vld;
   assign bus.mem_raddr = raddr_q;
   assign bus.rdy       = rdy_q;
   assign bus.data      = data_q;

`ifdef MEM_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (grant_valid && grant_cnt != '1) grant_cnt <= grant_cnt + 32'd1;
         if ((|bus.req) && !(|eligible) && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Scoreboard bench for rr_mem_arbiter: an 8-channel/latency-1 and a 5-channel/latency-3 instance.
`timescale 1ns/1ps
module tb_rr_mem_arbiter;

   localparam int AW = 9;
   localparam int DW = 8;
   localparam int NA = 8;
   localparam int LA = 1;
   localparam int NB = 5;
   localparam int LB = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   rr_mem_arbiter_if #(.NUM_CHANNELS(NA), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
   rr_mem_arbiter_if #(.NUM_CHANNELS(NB), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

`ifdef MEM_ARB_STATS_EN
   logic [31:0] gcnt_a, scnt_a, gcnt_b, scnt_b;
`endif

   rr_mem_arbiter #(.NUM_CHANNELS(NA), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LA)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
`ifdef MEM_ARB_STATS_EN
      , .grant_cnt (gcnt_a), .stall_cnt (scnt_a)
`endif
   );

   rr_mem_arbiter #(.NUM_CHANNELS(NB), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LB)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
`ifdef MEM_ARB_STATS_EN
      , .grant_cnt (gcnt_b), .stall_cnt (scnt_b)
`endif
   );

   // Shared BRAM contents; instance b sees a 3-clock read pipeline.
   logic [DW-1:0] bram [1<<AW];
   logic [DW-1:0] rd_b [LB];
   initial for (int i = 0; i < (1 << AW); i++) bram[i] = DW'($urandom);

   always @(posedge clk) bus_a.mem_rdata <= bram[bus_a.mem_raddr];
   always @(posedge clk) begin
      rd_b[0] <= bram[bus_b.mem_raddr];
      for (int k = 1; k < LB; k++) rd_b[k] <= rd_b[k-1];
   end
   assign bus_b.mem_rdata = rd_b[LB-1];

   // Reference model: a channel is busy from its grant through the edge its rdy appears.
   typedef struct { int ch; int data; int due; } exp_t;
   exp_t        sb [2][$];
   int          cyc = 0;
   bit [31:0]   m_req  [2];
   int          m_adr  [2][32];
   int          m_due  [2][32];
   int          m_ptr  [2];
   bit          m_ren  [2];
   int          m_raddr[2];
   int          m_gcnt [2];
   int          m_scnt [2];

   function automatic int pick(input bit [31:0] elig, input int ptr, input int n);
      for (int k = 0; k < n; k++) if (elig[(ptr + k) % n]) return (ptr + k) % n;
      return -1;
   endfunction

   task automatic model_reset(input int c);
      m_ptr[c] = 0; m_ren[c] = 1'b0; m_raddr[c] = 0; m_gcnt[c] = 0; m_scnt[c] = 0;
      for (int i = 0; i < 32; i++) m_due[c][i] = -1;
      sb[c].delete();
   endtask

   task automatic model_step(input int c, input int n, input int lat);
      bit [31:0] elig;
      int        g;
      elig = '0;
      for (int i = 0; i < n; i++) elig[i] = m_req[c][i] && (m_due[c][i] < cyc);
      g = pick(elig, m_ptr[c], n);
      m_ren[c] = (g >= 0);
      if (m_req[c] != 0 && elig == 0) m_scnt[c]++;
      if (g >= 0) begin
         m_raddr[c]  = m_adr[c][g];
         m_ptr[c]    = (g + 1) % n;
         m_due[c][g] = cyc + lat + 1;
         m_gcnt[c]++;
         sb[c].push_back('{ch: g, data: int'(bram[m_adr[c][g]]), due: cyc + lat + 1});
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         model_reset(0);
         model_reset(1);
      end else begin
         m_req[0] = 32'(bus_a.req);
         m_req[1] = 32'(bus_b.req);
         for (int i = 0; i < NA; i++) m_adr[0][i] = int'(bus_a.addr[i*AW +: AW]);
         for (int i = 0; i < NB; i++) m_adr[1][i] = int'(bus_b.addr[i*AW +: AW]);
         model_step(0, NA, LA);
         model_step(1, NB, LB);
      end
   end

   // Monitor: every comparison happens here, on the falling edge.
   int checks = 0;
   int errors = 0;
   bit end_chk = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic mon(input int c, input bit [31:0] rdy, input int data, input bit ren, input int raddr);
      string tg;
      exp_t  e;
      tg = (c == 0) ? "a" : "b";
      if (!rst_n) begin
         chk({tg, "_rst_rdy"}, rdy, 0);
         chk({tg, "_rst_ren"}, ren, 0);
         chk({tg, "_rst_raddr"}, raddr, 0);
         return;
      end
      chk({tg, "_mem_ren"}, ren, m_ren[c]);
      chk({tg, "_mem_raddr"}, raddr, m_raddr[c]);
      if (rdy != 0) begin
         if (sb[c].size() == 0) chk({tg, "_rdy_unexpected"}, rdy, 0);
         else begin
            e = sb[c].pop_front();
            chk({tg, "_rdy_chan"}, rdy, 32'(1) << e.ch);
            chk({tg, "_data"}, data, e.data);
            chk({tg, "_rdy_cycle"}, cyc, e.due);
         end
      end else if (sb[c].size() > 0 && sb[c][0].due <= cyc) begin
         e = sb[c].pop_front();
         chk({tg, "_rdy_missing"}, 0, 32'(1) << e.ch);
      end
   endtask

   always @(negedge clk) begin
      mon(0, 32'(bus_a.rdy), int'(bus_a.data), bus_a.mem_ren, int'(bus_a.mem_raddr));
      mon(1, 32'(bus_b.rdy), int'(bus_b.data), bus_b.mem_ren, int'(bus_b.mem_raddr));
`ifdef MEM_ARB_STATS_EN
      chk("a_grant_cnt", gcnt_a, rst_n ? m_gcnt[0] : 0);
      chk("a_stall_cnt", scnt_a, rst_n ? m_scnt[0] : 0);
      chk("b_grant_cnt", gcnt_b, rst_n ? m_gcnt[1] : 0);
      chk("b_stall_cnt", scnt_b, rst_n ? m_scnt[1] : 0);
`endif
      if (end_chk) begin
         chk("a_drain", sb[0].size(), 0);
         chk("b_drain", sb[1].size(), 0);
      end
   end

   // Stimulus: mode 0 holds req, 1 drops req on rdy, 2 random traffic.
   int mode_a = 0;
   int mode_b = 0;

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < NA; i++) begin
         if (mode_a != 0 && bus_a.rdy[i]) begin
            if (mode_a == 2 && $urandom_range(1, 0) == 1) bus_a.addr[i*AW +: AW] = AW'($urandom);
            else bus_a.req[i] = 1'b0;
         end else if (mode_a == 2 && !bus_a.req[i] && $urandom_range(3, 0) == 0) begin
            bus_a.req[i] = 1'b1;
            bus_a.addr[i*AW +: AW] = AW'($urandom);
         end else if (mode_a == 2 && bus_a.req[i] && $urandom_range(7, 0) == 0)
            bus_a.addr[i*AW +: AW] = AW'($urandom);
      end
      for (int i = 0; i < NB; i++) begin
         if (mode_b != 0 && bus_b.rdy[i]) begin
            if (mode_b == 2 && $urandom_range(1, 0) == 1) bus_b.addr[i*AW +: AW] = AW'($urandom);
            else bus_b.req[i] = 1'b0;
         end else if (mode_b == 2 && !bus_b.req[i] && $urandom_range(2, 0) == 0) begin
            bus_b.req[i] = 1'b1;
            bus_b.addr[i*AW +: AW] = AW'($urandom);
         end else if (mode_b == 2 && bus_b.req[i] && $urandom_range(7, 0) == 0)
            bus_b.addr[i*AW +: AW] = AW'($urandom);
      end
   endtask

   initial begin
      bus_a.req  = '0;
      bus_a.addr = '0;
      bus_b.req  = '0;
      bus_b.addr = '0;
      for (int i = 0; i < NA; i++) bus_a.addr[i*AW +: AW] = AW'($urandom);
      for (int i = 0; i < NB; i++) bus_b.addr[i*AW +: AW] = AW'($urandom);

      // Reset with every channel requesting, then all eight held: order 0..7 and re-grant after rdy
      #2 rst_n = 1'b0;
      bus_a.req = '1;
      repeat (3) step();
      rst_n = 1'b1;
      repeat (20) step();
      mode_a = 1;
      repeat (12) step();

      // Single channel 3 at 0x0B4
      bus_a.addr[3*AW +: AW] = 9'h0B4;
      bus_a.req = 8'h08;
      repeat (6) step();

      // Move ptr to 6, then wrap 7 -> 0, then ptr=1 makes channel 1 win over 0
      bus_a.req = 8'h20;
      repeat (5) step();
      bus_a.req = 8'h81;
      repeat (8) step();
      bus_a.req = 8'h03;
      repeat (8) step();

      // Reset one cycle after a grant: that read must never produce rdy
      bus_a.addr[2*AW +: AW] = AW'($urandom);
      bus_a.req = 8'h04;
      step();
      step();
      rst_n = 1'b0;
      bus_a.req = '0;
      repeat (3) step();
      rst_n = 1'b1;
      repeat (8) step();

      // Random traffic on both instances, then drain
      mode_a = 2;
      mode_b = 2;
      repeat (600) step();
      mode_a = 1;
      mode_b = 1;
      repeat (40) step();

      end_chk = 1'b1;
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
